// File: rtl/scheduler_pkg.sv
// Shared types, opcodes and the RV32I decode helper for the dual-issue scheduler.
// Optional feature macro used by the top: SCHED_PERF_CNT_EN.
package scheduler_pkg;

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned REG_AW   = $clog2(NUM_REGS);
   localparam int unsigned PERF_W   = 32;
   localparam int unsigned INSTR_W  = 32;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic {RUN = 1'b0, CTRL_WAIT = 1'b1} sched_state_e;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              uses_rs1;
      logic              uses_rs2;
      logic              writes_rd;
      logic              is_mem;
      logic              is_ctrl;
   } decoded_t;

   // Register usage per opcode; unknown opcodes touch no registers
   function automatic decoded_t decode(input logic [INSTR_W-1:0] instr);
      decoded_t d;
      logic     unused_bits;
      d           = '0;
      unused_bits = ^{instr[31:25], instr[14:12]};
      d.rd        = instr[11:7];
      d.rs1       = instr[19:15];
      d.rs2       = instr[24:20];
      case (instr[6:0])
         OP_LOAD:   begin d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; d.is_mem = 1'b1; end
         OP_STORE:  begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.is_mem = 1'b1; end
         OP_BRANCH: begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.is_ctrl = 1'b1; end
         OP_JAL:    begin d.writes_rd = 1'b1; d.is_ctrl = 1'b1; end
         OP_JALR:   begin d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; d.is_ctrl = 1'b1; end
         OP_OP:     begin d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.writes_rd = 1'b1; end
         OP_IMM:    begin d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; end
         OP_LUI,
         OP_AUIPC:  d.writes_rd = 1'b1;
         default:   ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/dual_issue_scheduler_if.sv
// Fetch-buffer, writeback and issue-lane signals of the dual-issue scheduler.
interface dual_issue_scheduler_if;
   import scheduler_pkg::*;

   logic                nothing_filled;
   logic [INSTR_W-1:0]  instruction0;
   logic [INSTR_W-1:0]  instruction1;
   logic                freeze1;
   logic                freeze2;
   logic                dependency_on_ins2;
   logic                ex_stall;
   logic                wb0_valid;
   logic [REG_AW-1:0]   wb0_rd;
   logic                wb1_valid;
   logic [REG_AW-1:0]   wb1_rd;
   logic                branch_resolved;
   logic                issue0_valid;
   logic [INSTR_W-1:0]  issue0_instr;
   logic                issue1_valid;
   logic [INSTR_W-1:0]  issue1_instr;
   logic [PERF_W-1:0]   perf_dual;
   logic [PERF_W-1:0]   perf_single;
   logic [PERF_W-1:0]   perf_stall;

   modport master (
      output nothing_filled, instruction0, instruction1, ex_stall,
             wb0_valid, wb0_rd, wb1_valid, wb1_rd, branch_resolved,
      input  freeze1, freeze2, dependency_on_ins2,
             issue0_valid, issue0_instr, issue1_valid, issue1_instr,
             perf_dual, perf_single, perf_stall
   );

   modport slave (
      input  nothing_filled, instruction0, instruction1, ex_stall,
             wb0_valid, wb0_rd, wb1_valid, wb1_rd, branch_resolved,
      output freeze1, freeze2, dependency_on_ins2,
             issue0_valid, issue0_instr, issue1_valid, issue1_instr,
             perf_dual, perf_single, perf_stall
   );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-destination scoreboard with writeback bypass on the read view; x0 never pending.
module reg_scoreboard
   import scheduler_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr0_en,
   input  logic [REG_AW-1:0]   clr0_idx,
   input  logic                clr1_en,
   input  logic [REG_AW-1:0]   clr1_idx,
   input  logic                set0_en,
   input  logic [REG_AW-1:0]   set0_idx,
   input  logic                set1_en,
   input  logic [REG_AW-1:0]   set1_idx,
   output logic [NUM_REGS-1:0] view_c
);

   localparam logic [NUM_REGS-1:0] X0_MASK = NUM_REGS'(1);

   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pending_next;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] set_mask;

   // Clears apply first, then sets, so an issue wins over a same-cycle writeback
   always_comb begin
      clr_mask = '0;
      set_mask = '0;
      if (clr0_en) clr_mask[clr0_idx] = 1'b1;
      if (clr1_en) clr_mask[clr1_idx] = 1'b1;
      if (set0_en) set_mask[set0_idx] = 1'b1;
      if (set1_en) set_mask[set1_idx] = 1'b1;
      pending_next = ((pending & ~clr_mask) | set_mask) & ~X0_MASK;
      view_c       = pending & ~clr_mask & ~X0_MASK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= pending_next;
   end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Dual-issue stage: picks 0/1/2 instructions per cycle from the fetch buffer using a register scoreboard.
// Optional: SCHED_PERF_CNT_EN enables saturating dual/single/stall cycle counters.
module dual_issue_scheduler
   import scheduler_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   dual_issue_scheduler_if.slave  bus
);

   sched_state_e        state;
   sched_state_e        next_state;
   decoded_t            d0;
   decoded_t            d1;
   logic [NUM_REGS-1:0] view;
   logic                pend0;
   logic                pend1;
   logic                raw;
   logic                waw;
   logic                blocked0;
   logic                single;
   logic                issue0;
   logic                issue1;

   reg_scoreboard u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr0_en  (bus.wb0_valid),
      .clr0_idx (bus.wb0_rd),
      .clr1_en  (bus.wb1_valid),
      .clr1_idx (bus.wb1_rd),
      .set0_en  (issue0 && d0.writes_rd && (d0.rd != '0)),
      .set0_idx (d0.rd),
      .set1_en  (issue1 && d1.writes_rd && (d1.rd != '0)),
      .set1_idx (d1.rd),
      .view_c   (view)
   );

   // Issue decision and FSM next state
   always_comb begin
      d0       = decode(bus.instruction0);
      d1       = decode(bus.instruction1);
      pend0    = (d0.uses_rs1 && view[d0.rs1]) || (d0.uses_rs2 && view[d0.rs2]);
      pend1    = (d1.uses_rs1 && view[d1.rs1]) || (d1.uses_rs2 && view[d1.rs2]);
      raw      = d0.writes_rd && (d0.rd != '0) &&
                 ((d1.uses_rs1 && (d1.rs1 == d0.rd)) || (d1.uses_rs2 && (d1.rs2 == d0.rd)));
      waw      = d0.writes_rd && d1.writes_rd && (d0.rd != '0) && (d0.rd == d1.rd);
      blocked0 = bus.nothing_filled || bus.ex_stall || (state == CTRL_WAIT) ||
                 (bus.instruction0 == '0) || pend0;
      single   = (bus.instruction1 == '0) || pend1 || raw || waw ||
                 (d0.is_mem && d1.is_mem) || d0.is_ctrl || d1.is_ctrl;
      issue0   = !blocked0;
      issue1   = !blocked0 && !single;

      next_state = state;
      case (state)
         RUN:       if (issue0 && d0.is_ctrl) next_state = CTRL_WAIT;
         CTRL_WAIT: if (bus.branch_resolved)  next_state = RUN;
         default:   next_state = RUN;
      endcase
   end

   assign bus.freeze1            = blocked0 && !bus.nothing_filled;
   assign bus.dependency_on_ins2 = issue0 && single;
   assign bus.freeze2            = bus.freeze1 || (state == CTRL_WAIT) || (issue0 && d0.is_ctrl);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= RUN;
         bus.issue0_valid <= 1'b0;
         bus.issue0_instr <= '0;
         bus.issue1_valid <= 1'b0;
         bus.issue1_instr <= '0;
      end else begin
         state            <= next_state;
         bus.issue0_valid <= issue0;
         bus.issue0_instr <= issue0 ? bus.instruction0 : '0;
         bus.issue1_valid <= issue1;
         bus.issue1_instr <= issue1 ? bus.instruction1 : '0;
      end
   end

`ifdef SCHED_PERF_CNT_EN
   localparam logic [PERF_W-1:0] PERF_MAX = '1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.perf_dual   <= '0;
         bus.perf_single <= '0;
         bus.perf_stall  <= '0;
      end else begin
         if (issue1 && (bus.perf_dual != PERF_MAX))
            bus.perf_dual <= bus.perf_dual + PERF_W'(1);
         if (bus.dependency_on_ins2 && (bus.perf_single != PERF_MAX))
            bus.perf_single <= bus.perf_single + PERF_W'(1);
         if (bus.freeze1 && (bus.perf_stall != PERF_MAX))
            bus.perf_stall <= bus.perf_stall + PERF_W'(1);
      end
   end
`else
   assign bus.perf_dual   = '0;
   assign bus.perf_single = '0;
   assign bus.perf_stall  = '0;
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: single-cycle vector table plus multi-cycle sequences.
module tb_dual_issue_scheduler;
   import scheduler_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dual_issue_scheduler_if bus();

   dual_issue_scheduler dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic        nf;
      logic        stall;
      logic [31:0] i0;
      logic [31:0] i1;
      logic        f1;
      logic        f2;
      logic        dep;
      logic        v0;
      logic        v1;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.nothing_filled  = 1'b0;
      bus.ex_stall        = 1'b0;
      bus.instruction0    = '0;
      bus.instruction1    = '0;
      bus.wb0_valid       = 1'b0;
      bus.wb0_rd          = '0;
      bus.wb1_valid       = 1'b0;
      bus.wb1_rd          = '0;
      bus.branch_resolved = 1'b0;
   endtask

   // Leaves time at posedge+1 with reset released
   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic set_instr(input logic [31:0] i0, input logic [31:0] i1);
      bus.instruction0 = i0;
      bus.instruction1 = i1;
   endtask

   task automatic chk_comb(input string tag, input logic f1, input logic f2, input logic dep);
      chk($sformatf("%s.freeze1", tag), 32'(bus.freeze1), 32'(f1));
      chk($sformatf("%s.freeze2", tag), 32'(bus.freeze2), 32'(f2));
      chk($sformatf("%s.dep", tag), 32'(bus.dependency_on_ins2), 32'(dep));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //         name         nf    stall i0            i1            f1    f2    dep   v0    v1
      vecs[0]  = '{"dual",     1'b0, 1'b0, 32'h00500093, 32'h000001b3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[1]  = '{"raw",      1'b0, 1'b0, 32'h00500093, 32'h00108113, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{"ld_st",    1'b0, 1'b0, 32'h00002203, 32'h00502023, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{"beq0",     1'b0, 1'b0, 32'h00000463, 32'h00500093, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{"empty",    1'b1, 1'b0, 32'h00500093, 32'h000001b3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{"stall",    1'b0, 1'b1, 32'h00500093, 32'h000001b3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{"bubble0",  1'b0, 1'b0, 32'h00000000, 32'h00500093, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{"bubble1",  1'b0, 1'b0, 32'h00500093, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{"waw",      1'b0, 1'b0, 32'h00500093, 32'h00700093, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{"jal1",     1'b0, 1'b0, 32'h000001b3, 32'h000000ef, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{"waw_x0",   1'b0, 1'b0, 32'h00000013, 32'h00100013, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[11] = '{"raw_x0",   1'b0, 1'b0, 32'h00000013, 32'h00100113, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[12] = '{"lui_auipc",1'b0, 1'b0, 32'h000052b7, 32'h00000317, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[13] = '{"st_st",    1'b0, 1'b0, 32'h00502023, 32'h00602223, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

      rst_n = 1'b0;
      idle();
      #12;
      chk("reset.issue0_valid", 32'(bus.issue0_valid), 32'd0);
      chk("reset.issue1_valid", 32'(bus.issue1_valid), 32'd0);
      chk("reset.issue0_instr", bus.issue0_instr, 32'd0);
      chk("reset.pending", dut.u_sb.pending, 32'd0);

      for (int k = 0; k < NV; k++) begin
         do_reset();
         bus.nothing_filled = vecs[k].nf;
         bus.ex_stall       = vecs[k].stall;
         set_instr(vecs[k].i0, vecs[k].i1);
         #1;
         chk_comb(vecs[k].name, vecs[k].f1, vecs[k].f2, vecs[k].dep);
         tick();
         chk($sformatf("%s.issue0_valid", vecs[k].name), 32'(bus.issue0_valid), 32'(vecs[k].v0));
         chk($sformatf("%s.issue0_instr", vecs[k].name), bus.issue0_instr, vecs[k].v0 ? vecs[k].i0 : 32'd0);
         chk($sformatf("%s.issue1_valid", vecs[k].name), 32'(bus.issue1_valid), 32'(vecs[k].v1));
         chk($sformatf("%s.issue1_instr", vecs[k].name), bus.issue1_instr, vecs[k].v1 ? vecs[k].i1 : 32'd0);
      end

      // Dual issue marks x1 and x3 pending
      do_reset();
      set_instr(32'h00500093, 32'h000001b3);
      tick();
      chk("dual.pending", dut.u_sb.pending, 32'h0000000a);

      // RAW split, blocked slot0 until writeback, then same-cycle bypass
      do_reset();
      set_instr(32'h00500093, 32'h00108113);
      #1;
      chk_comb("split", 1'b0, 1'b0, 1'b1);
      tick();
      chk("split.pending", dut.u_sb.pending, 32'h00000002);
      set_instr(32'h00108113, 32'h00000000);
      for (int c = 0; c < 2; c++) begin
         #1;
         chk_comb($sformatf("blocked%0d", c), 1'b1, 1'b1, 1'b0);
         tick();
         chk($sformatf("blocked%0d.issue0_valid", c), 32'(bus.issue0_valid), 32'd0);
      end
      bus.wb0_valid = 1'b1;
      bus.wb0_rd    = 5'd1;
      #1;
      chk_comb("bypass", 1'b0, 1'b0, 1'b1);
      tick();
      bus.wb0_valid = 1'b0;
      chk("bypass.issue0_valid", 32'(bus.issue0_valid), 32'd1);
      chk("bypass.issue0_instr", bus.issue0_instr, 32'h00108113);
      chk("bypass.pending", dut.u_sb.pending, 32'h00000004);

      // Set wins over a same-cycle clear of the same register
      set_instr(32'h00100113, 32'h00000000);
      bus.wb1_valid = 1'b1;
      bus.wb1_rd    = 5'd2;
      #1;
      chk_comb("setwin", 1'b0, 1'b0, 1'b1);
      tick();
      bus.wb1_valid = 1'b0;
      chk("setwin.pending", dut.u_sb.pending, 32'h00000004);

      // Both writeback lanes name the same register
      bus.nothing_filled = 1'b1;
      set_instr(32'h00000000, 32'h00000000);
      bus.wb0_valid = 1'b1;
      bus.wb0_rd    = 5'd2;
      bus.wb1_valid = 1'b1;
      bus.wb1_rd    = 5'd2;
      #1;
      chk_comb("dblclr", 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      chk("dblclr.pending", dut.u_sb.pending, 32'h00000000);

      // Branch: resolve in issuing cycle ignored, hold until pulse, resume next cycle
      do_reset();
      set_instr(32'h00000463, 32'h00500093);
      bus.branch_resolved = 1'b1;
      #1;
      chk_comb("br_issue", 1'b0, 1'b1, 1'b1);
      tick();
      bus.branch_resolved = 1'b0;
      chk("br_issue.issue0_valid", 32'(bus.issue0_valid), 32'd1);
      chk("br_issue.issue1_valid", 32'(bus.issue1_valid), 32'd0);
      set_instr(32'h00500093, 32'h00000000);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk_comb($sformatf("br_wait%0d", c), 1'b1, 1'b1, 1'b0);
         tick();
         chk($sformatf("br_wait%0d.issue0_valid", c), 32'(bus.issue0_valid), 32'd0);
      end
      bus.branch_resolved = 1'b1;
      #1;
      chk_comb("br_pulse", 1'b1, 1'b1, 1'b0);
      tick();
      bus.branch_resolved = 1'b0;
      #1;
      chk_comb("br_run", 1'b0, 1'b0, 1'b1);
      tick();
      chk("br_run.issue0_valid", 32'(bus.issue0_valid), 32'd1);
      chk("br_run.issue0_instr", bus.issue0_instr, 32'h00500093);

      // Asynchronous reset while waiting on a jal with x1 pending
      do_reset();
      set_instr(32'h000000ef, 32'h00000000);
      #1;
      chk_comb("jal", 1'b0, 1'b1, 1'b1);
      tick();
      chk("jal.pending", dut.u_sb.pending, 32'h00000002);
      set_instr(32'h00108113, 32'h00000000);
      #1;
      chk_comb("jal_wait", 1'b1, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.issue0_valid", 32'(bus.issue0_valid), 32'd0);
      chk("arst.issue0_instr", bus.issue0_instr, 32'd0);
      chk("arst.pending", dut.u_sb.pending, 32'd0);
      chk_comb("arst", 1'b0, 1'b0, 1'b1);
      chk("arst.perf_dual", bus.perf_dual, 32'd0);
      chk("arst.perf_single", bus.perf_single, 32'd0);
      chk("arst.perf_stall", bus.perf_stall, 32'd0);
      tick();
      rst_n = 1'b1;
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
